mem_lsu: RTL

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM register and the MEM/WB register. It executes loads and stores over an SRAM-like request/response data port, aligns and sign-extends load data, and replicates store data across byte lanes. It reports address-alignment exceptions and requests a pipeline stall from ctrl while a memory transaction is outstanding. Non-memory results pass through unchanged toward MEM/WB.

---
 rtl/mem_lsu.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// mem_lsu - memory-access stage of the five-stage MIPS pipeline.
//
// Executes loads and stores over an SRAM-like request/response port.
// Load data is aligned and sign/zero-extended. Store data is replicated
// across byte lanes. Misaligned halfword/word accesses raise
// exc_adel/exc_ades instead of issuing a request. While a transaction is
// outstanding, stallreq holds the pipeline. Non-memory results pass
// straight through to MEM/WB.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush, stall[5:0]   pipeline control from ctrl (stall[4] = MEM/WB hold)
//   ex_*                EX/MEM register fields (op, address, store data, results)
//   mem_*               fields toward the MEM/WB register
//   stallreq            stall request to ctrl
//   data_*              SRAM-like data port (req/wr/size/addr/wdata out;
//                       addr_ok/data_ok/rdata in)
//   exc_adel, exc_ades  load / store address error
//   badvaddr            faulting address, 0 when no address error
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [5:0]  stall,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic        ex_cp0_reg_we,
  input  logic [4:0]  ex_cp0_reg_write_addr,
  input  logic [31:0] ex_cp0_reg_data,
  input  logic [31:0] ex_pc,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic        mem_cp0_reg_we,
  output logic [4:0]  mem_cp0_reg_write_addr,
  output logic [31:0] mem_cp0_reg_data,
  output logic [31:0] mem_pc,
  output logic        stallreq,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] badvaddr
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DONE    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      state_r;
  logic [31:0] rdata_q;

  logic        is_load_s;
  logic        is_store_s;
  logic        is_signed_s;
  logic [1:0]  size_s;
  logic        misalign_s;
  logic        fault_s;
  logic        go_s;
  logic [31:0] load_ext_s;

  // Only the MEM/WB hold bit of the stall vector matters to this stage.
  logic        unused_stall_s;
  assign unused_stall_s = ^{stall[5], stall[3:0]};

  // Pick the addressed byte/halfword out of the load word and extend it.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        sign,
                                               input logic [1:0]  addr_lo);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (addr_lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    if (addr_lo[1]) begin
      half_v = word[31:16];
    end else begin
      half_v = word[15:0];
    end
    case (size)
      SZ_BYTE: res_v = {{24{sign & byte_v[7]}}, byte_v};
      SZ_HALF: res_v = {{16{sign & half_v[15]}}, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

  // Replicate store data so every byte lane the memory may pick holds it.
  function automatic logic [31:0] store_lanes(input logic [31:0] data,
                                              input logic [1:0]  size);
    logic [31:0] res_v;
    case (size)
      SZ_BYTE: res_v = {4{data[7:0]}};
      SZ_HALF: res_v = {2{data[15:0]}};
      default: res_v = data;
    endcase
    return res_v;
  endfunction

  // Decode the memory op into direction, access size and extension mode.
  always_comb begin
    is_load_s   = 1'b0;
    is_store_s  = 1'b0;
    is_signed_s = 1'b0;
    size_s      = SZ_BYTE;
    case (ex_mem_op)
      OP_LB:   begin is_load_s  = 1'b1; is_signed_s = 1'b1; size_s = SZ_BYTE; end
      OP_LBU:  begin is_load_s  = 1'b1; size_s = SZ_BYTE; end
      OP_LH:   begin is_load_s  = 1'b1; is_signed_s = 1'b1; size_s = SZ_HALF; end
      OP_LHU:  begin is_load_s  = 1'b1; size_s = SZ_HALF; end
      OP_LW:   begin is_load_s  = 1'b1; size_s = SZ_WORD; end
      OP_SB:   begin is_store_s = 1'b1; size_s = SZ_BYTE; end
      OP_SH:   begin is_store_s = 1'b1; size_s = SZ_HALF; end
      OP_SW:   begin is_store_s = 1'b1; size_s = SZ_WORD; end
      default: begin is_load_s  = 1'b0; is_store_s = 1'b0; size_s = SZ_BYTE; end
    endcase
  end

  // Natural-alignment check for the decoded access size.
  always_comb begin
    misalign_s = 1'b0;
    case (size_s)
      SZ_HALF: misalign_s = ex_mem_addr[0];
      SZ_WORD: misalign_s = (ex_mem_addr[1:0] != 2'd0);
      default: misalign_s = 1'b0;
    endcase
  end

  assign fault_s    = (is_load_s | is_store_s) & misalign_s;
  // A new request may only start from IDLE; the op stays on ex_* while stalled.
  assign go_s       = (state_r == ST_IDLE) & (is_load_s | is_store_s) & ~misalign_s
                      & ~flush & ~rst;
  assign load_ext_s = extract_load(data_rdata, size_s, is_signed_s, ex_mem_addr[1:0]);

  // Transaction FSM and the captured load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      rdata_q <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_s && data_addr_ok) begin
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // A response arriving with flush is consumed here, so no drain needed.
          if (data_data_ok) begin
            if (flush) begin
              state_r <= ST_IDLE;
            end else begin
              rdata_q <= load_ext_s;
              state_r <= ST_DONE;
            end
          end else if (flush) begin
            state_r <= ST_DISCARD;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          if (flush || !stall[4]) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        ST_DISCARD: begin
          if (data_data_ok) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DISCARD;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Stall while a request is presented or a response is still owed.
  always_comb begin
    stallreq = 1'b0;
    if (rst) begin
      stallreq = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:    stallreq = go_s;
        ST_WAIT:    stallreq = 1'b1;
        ST_DISCARD: stallreq = 1'b1;
        default:    stallreq = 1'b0;
      endcase
    end
  end

  // Loads present their captured result only once complete.
  always_comb begin
    mem_wdata = ex_wdata;
    if ((state_r == ST_DONE) && is_load_s) begin
      mem_wdata = rdata_q;
    end else begin
      mem_wdata = ex_wdata;
    end
  end

  assign data_req   = go_s;
  assign data_wr    = is_store_s;
  assign data_size  = size_s;
  assign data_addr  = ex_mem_addr;
  assign data_wdata = store_lanes(ex_store_data, size_s);

  assign exc_adel   = is_load_s & misalign_s;
  assign exc_ades   = is_store_s & misalign_s;
  assign badvaddr   = fault_s ? ex_mem_addr : 32'd0;

  // A faulting access must not retire a register write.
  assign mem_wreg               = ex_wreg & ~fault_s;
  assign mem_wd                 = ex_wd;
  assign mem_hi                 = ex_hi;
  assign mem_lo                 = ex_lo;
  assign mem_whilo              = ex_whilo;
  assign mem_cp0_reg_we         = ex_cp0_reg_we;
  assign mem_cp0_reg_write_addr = ex_cp0_reg_write_addr;
  assign mem_cp0_reg_data       = ex_cp0_reg_data;
  assign mem_pc                 = ex_pc;

endmodule
